// File: rtl/vga_pkg.sv
// Shared VGA constants and the hex-to-7-segment glyph table used by display encoders.
package vga_pkg;

    // Visible raster size; also the wrap moduli for glyph placement.
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;

    // Segment bit positions inside a seg_t vector (bit 0 = a ... bit 6 = g).
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    typedef logic [6:0] seg_t;

    // Standard active-high hex glyphs; literals are written g..a, MSB first.
    function automatic seg_t hex_to_seg(input logic [3:0] value);
        seg_t seg;
        case (value)
            4'h0:    seg = 7'b0111111;
            4'h1:    seg = 7'b0000110;
            4'h2:    seg = 7'b1011011;
            4'h3:    seg = 7'b1001111;
            4'h4:    seg = 7'b1100110;
            4'h5:    seg = 7'b1101101;
            4'h6:    seg = 7'b1111101;
            4'h7:    seg = 7'b0000111;
            4'h8:    seg = 7'b1111111;
            4'h9:    seg = 7'b1101111;
            4'hA:    seg = 7'b1110111;
            4'hB:    seg = 7'b1111100;
            4'hC:    seg = 7'b0111001;
            4'hD:    seg = 7'b1011110;
            4'hE:    seg = 7'b1111001;
            default: seg = 7'b1110001;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/digit_pixel_renderer_if.sv
// Pixel-scan and digit-location signals between the VGA counter side and the renderer.
interface digit_pixel_renderer_if;

    logic       frame_start;
    logic       pix_valid;
    logic [9:0] CounterX;
    logic [9:0] CounterY;
    logic [9:0] DigitX;
    logic [9:0] DigitY;
    logic [3:0] digit_value;
    logic       digit_blank;
    logic       pixel_valid;
    logic       pixel_on;

    modport master (
        output frame_start, pix_valid, CounterX, CounterY,
               DigitX, DigitY, digit_value, digit_blank,
        input  pixel_valid, pixel_on
    );

    modport slave (
        input  frame_start, pix_valid, CounterX, CounterY,
               DigitX, DigitY, digit_value, digit_blank,
        output pixel_valid, pixel_on
    );

endinterface

// File: rtl/seven_seg_decoder.sv
// Combinational 4-bit value to 7-segment enable decoder (bit order a..g).
module seven_seg_decoder
    import vga_pkg::*;
(
    input  logic [3:0] value,
    output seg_t       seg_en
);

    assign seg_en = hex_to_seg(value);

endmodule

// File: rtl/digit_pixel_renderer.sv
// Per-pixel 7-segment glyph coverage: frame-latched digit position/value, 2-stage pipeline.
module digit_pixel_renderer #(
    parameter int unsigned DIGIT_W  = 40,
    parameter int unsigned DIGIT_H  = 80,
    parameter int unsigned SEG_T    = 8,
    parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE
) (
    input logic                  clock,
    input logic                  reset,
    digit_pixel_renderer_if.slave bus
);

    import vga_pkg::*;

    localparam logic [9:0] H_LIM  = 10'(H_ACTIVE);
    localparam logic [9:0] V_LIM  = 10'(V_ACTIVE);
    localparam logic [9:0] W_LIM  = 10'(DIGIT_W);
    localparam logic [9:0] GH_LIM = 10'(DIGIT_H);
    localparam logic [9:0] T_LIM  = 10'(SEG_T);
    localparam logic [9:0] B_X    = 10'(DIGIT_W - SEG_T);
    localparam logic [9:0] D_Y    = 10'(DIGIT_H - SEG_T);
    localparam logic [9:0] MID_Y  = 10'(DIGIT_H / 2);
    localparam logic [9:0] G_LO   = 10'(DIGIT_H / 2 - SEG_T / 2);
    localparam logic [9:0] G_HI   = 10'(DIGIT_H / 2 + SEG_T / 2);

    // Shadow registers (frame-stable digit position/value)
    logic [9:0] sx_q, sx_d, sy_q, sy_d, sy_once;
    logic [3:0] val_q, val_d;
    logic       blank_q, blank_d;

    // Stage 1 registers
    logic [9:0] dx1_q, dx1_d, dy1_q, dy1_d;
    logic       inbox1_q, inbox1_d, v1_q, v1_d, blank1_q, blank1_d;
    seg_t       seg1_q, seg1_d;

    // Stage 2 registers
    logic       pixel_valid_q, pixel_valid_d, pixel_on_q, pixel_on_d;
    seg_t       seg_en, hit;

    seven_seg_decoder u_decoder (
        .value  (val_q),
        .seg_en (seg_en)
    );

    // Shadow load on frame_start, reducing the position into the visible raster.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        sx_d    = sx_q;
        sy_d    = sy_q;
        val_d   = val_q;
        blank_d = blank_q;
        sy_once = (bus.DigitY >= V_LIM) ? bus.DigitY - V_LIM : bus.DigitY;
        if (bus.frame_start) begin
            sx_d    = (bus.DigitX >= H_LIM) ? bus.DigitX - H_LIM : bus.DigitX;
            sy_d    = (sy_once >= V_LIM) ? sy_once - V_LIM : sy_once;
            val_d   = bus.digit_value;
            blank_d = bus.digit_blank;
        end
    end

    // Stage 1: wrapped glyph-relative offsets and bounding-box test. The glyph value and
    // blank flag travel with the pixel so a same-cycle frame_start cannot affect it.
    always_comb begin
        // The wrapped difference is always below the modulus, so 10 bits hold it exactly.
        dx1_d    = (bus.CounterX >= sx_q) ? bus.CounterX - sx_q : bus.CounterX + H_LIM - sx_q;
        dy1_d    = (bus.CounterY >= sy_q) ? bus.CounterY - sy_q : bus.CounterY + V_LIM - sy_q;
        inbox1_d = (dx1_d < W_LIM) && (dy1_d < GH_LIM)
                && (bus.CounterX < H_LIM) && (bus.CounterY < V_LIM);
        v1_d     = bus.pix_valid;
        seg1_d   = seg_en;
        blank1_d = blank_q;
    end

    // Stage 2: segment region hits masked by the enabled segments of the glyph.
    always_comb begin
        hit            = '0;
        hit[SEG_A]     = dy1_q < T_LIM;
        hit[SEG_D]     = dy1_q >= D_Y;
        hit[SEG_G]     = (dy1_q >= G_LO) && (dy1_q < G_HI);
        hit[SEG_F]     = (dx1_q < T_LIM) && (dy1_q < MID_Y);
        hit[SEG_B]     = (dx1_q >= B_X)  && (dy1_q < MID_Y);
        hit[SEG_E]     = (dx1_q < T_LIM) && (dy1_q >= MID_Y);
        hit[SEG_C]     = (dx1_q >= B_X)  && (dy1_q >= MID_Y);
        pixel_on_d     = v1_q & inbox1_q & ~blank1_q & (|(hit & seg1_q));
        pixel_valid_d  = v1_q;
    end

    // State registers with synchronous reset; blank shadow starts set so nothing draws early.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            sx_q          <= '0;
            sy_q          <= '0;
            val_q         <= '0;
            blank_q       <= 1'b1;
            dx1_q         <= '0;
            dy1_q         <= '0;
            inbox1_q      <= 1'b0;
            v1_q          <= 1'b0;
            seg1_q        <= '0;
            blank1_q      <= 1'b1;
            pixel_valid_q <= 1'b0;
            pixel_on_q    <= 1'b0;
        end else begin
            sx_q          <= sx_d;
            sy_q          <= sy_d;
            val_q         <= val_d;
            blank_q       <= blank_d;
            dx1_q         <= dx1_d;
            dy1_q         <= dy1_d;
            inbox1_q      <= inbox1_d;
            v1_q          <= v1_d;
            seg1_q        <= seg1_d;
            blank1_q      <= blank1_d;
            pixel_valid_q <= pixel_valid_d;
            pixel_on_q    <= pixel_on_d;
        end
    end

    assign bus.pixel_valid = pixel_valid_q;
    assign bus.pixel_on    = pixel_on_q;

endmodule

// File: tb/tb_digit_pixel_renderer.sv
// Self-checking bench for digit_pixel_renderer: directed glyph probes plus randomized streams.
module tb_digit_pixel_renderer;

    localparam int W  = 40;
    localparam int H  = 80;
    localparam int T  = 8;
    localparam int HA = 640;
    localparam int VA = 480;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    digit_pixel_renderer_if bus ();

    digit_pixel_renderer #(
        .DIGIT_W (W), .DIGIT_H (H), .SEG_T (T), .H_ACTIVE (HA), .V_ACTIVE (VA)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference shadow of what the renderer should currently be drawing.
    int m_sx, m_sy, m_val;
    bit m_blank;

    // Lit segments of each hex glyph, by letter.
    string seg_str [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                            "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    typedef struct { bit v; bit on; int x; int y; } exp_t;

    // Does the glyph described by the model shadow cover pixel (cx,cy)?
    function automatic bit model_on(input int cx, input int cy, input bit valid);
        int    dx, dy;
        byte   c;
        string s;
        if (!valid || m_blank || cx >= HA || cy >= VA) return 1'b0;
        dx = (cx - m_sx + HA) % HA;
        dy = (cy - m_sy + VA) % VA;
        if (dx >= W || dy >= H) return 1'b0;
        s = seg_str[m_val];
        for (int k = 0; k < s.len(); k++) begin
            c = s.getc(k);
            if (c == "a" && dy < T) return 1'b1;
            if (c == "d" && dy >= H - T) return 1'b1;
            if (c == "g" && dy >= H/2 - T/2 && dy < H/2 + T/2) return 1'b1;
            if (c == "f" && dx < T && dy < H/2) return 1'b1;
            if (c == "b" && dx >= W - T && dy < H/2) return 1'b1;
            if (c == "e" && dx < T && dy >= H/2) return 1'b1;
            if (c == "c" && dx >= W - T && dy >= H/2) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_sx = 0; m_sy = 0; m_val = 0; m_blank = 1'b1;
    endtask

    // Pulse frame_start with the given digit (pix_valid left as the caller set it).
    task automatic load_frame(input int x, input int y, input int val, input bit blank);
        bus.DigitX      = 10'(x);
        bus.DigitY      = 10'(y);
        bus.digit_value = 4'(val);
        bus.digit_blank = blank;
        bus.frame_start = 1'b1;
        @(posedge clock); #1;
        bus.frame_start = 1'b0;
        m_sx = x % HA; m_sy = y % VA; m_val = val; m_blank = blank;
    endtask

    // Present one valid pixel, then idle, and return the outputs two cycles later.
    task automatic probe(input int cx, input int cy, output logic pv, output logic po);
        bus.CounterX  = 10'(cx);
        bus.CounterY  = 10'(cy);
        bus.pix_valid = 1'b1;
        @(posedge clock); #1;
        bus.pix_valid = 1'b0;
        @(posedge clock); #1;
        pv = bus.pixel_valid;
        po = bus.pixel_on;
    endtask

    task automatic test_reset();
        exp_t q[$];
        exp_t e;
        reset = 1'b1;
        bus.pix_valid = 1'b1; bus.frame_start = 1'b1;
        bus.CounterX = 10'd100; bus.CounterY = 10'd40;
        bus.DigitX = 10'd100; bus.DigitY = 10'd40; bus.digit_value = 4'd8; bus.digit_blank = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            n_checks++;
            if (bus.pixel_valid !== 1'b0 || bus.pixel_on !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d: valid/on=%b%b expected 00", i, bus.pixel_valid, bus.pixel_on);
            end
        end
        model_reset();
        bus.frame_start = 1'b0;
        reset = 1'b0;
        // Coarse raster scan with no frame_start: nothing may ever be drawn.
        for (int y = 0; y < VA; y += 8) begin
            for (int x = 0; x < HA; x += 8) begin
                bus.CounterX  = 10'(x + (y % 8));
                bus.CounterY  = 10'(y);
                bus.pix_valid = ($urandom_range(0, 3) != 0);
                q.push_back('{v: bus.pix_valid, on: 1'b0, x: x, y: y});
                @(posedge clock); #1;
                if (q.size() == 2) begin
                    e = q.pop_front();
                    n_checks++;
                    if (bus.pixel_valid !== e.v || bus.pixel_on !== 1'b0) begin
                        n_fail++;
                        $display("FAIL reset_scan (%0d,%0d): valid/on=%b%b expected %b0",
                                 e.x, e.y, bus.pixel_valid, bus.pixel_on, e.v);
                    end
                end
            end
        end
        bus.pix_valid = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic run_table(input string name, input int n, input int px [5], input int py [5],
                             input bit ex [5]);
        logic pv, po;
        for (int i = 0; i < n; i++) begin
            probe(px[i], py[i], pv, po);
            n_checks++;
            if (pv !== 1'b1 || po !== ex[i]) begin
                n_fail++;
                $display("FAIL %s (%0d,%0d): valid/on=%b%b expected 1%b", name, px[i], py[i], pv, po, ex[i]);
            end
        end
    endtask

    task automatic test_glyph_eight();
        load_frame(100, 40, 8, 1'b0);
        run_table("glyph8", 5, '{100, 120, 139, 140, 99}, '{40, 60, 40, 40, 40}, '{1, 0, 1, 0, 0});
    endtask

    task automatic test_glyph_one();
        load_frame(100, 40, 1, 1'b0);
        run_table("glyph1", 3, '{100, 135, 135, 0, 0}, '{40, 50, 100, 0, 0}, '{0, 1, 1, 0, 0});
    endtask

    task automatic test_wrap();
        load_frame(620, 460, 8, 1'b0);
        run_table("wrap", 3, '{5, 20, 620, 0, 0}, '{460, 460, 20, 0, 0}, '{1, 0, 1, 0, 0});
    endtask

    task automatic test_frame_latch();
        load_frame(100, 40, 8, 1'b0);
        bus.DigitX = 10'd300;
        run_table("no_pulse", 2, '{100, 300, 0, 0, 0}, '{40, 40, 0, 0, 0}, '{1, 0, 0, 0, 0});
        load_frame(300, 40, 8, 1'b0);
        run_table("after_pulse", 2, '{100, 300, 0, 0, 0}, '{40, 40, 0, 0, 0}, '{0, 1, 0, 0, 0});
        // frame_start and a pixel in the same cycle: the pixel sees the old position.
        bus.DigitX = 10'd100; bus.DigitY = 10'd40;
        bus.frame_start = 1'b1;
        bus.CounterX = 10'd300; bus.CounterY = 10'd40; bus.pix_valid = 1'b1;
        @(posedge clock); #1;
        bus.frame_start = 1'b0; bus.pix_valid = 1'b0;
        m_sx = 100;
        @(posedge clock); #1;
        n_checks++;
        if (bus.pixel_valid !== 1'b1 || bus.pixel_on !== 1'b1) begin
            n_fail++;
            $display("FAIL same_cycle (300,40): valid/on=%b%b expected 11", bus.pixel_valid, bus.pixel_on);
        end
        run_table("same_cycle_after", 2, '{300, 100, 0, 0, 0}, '{40, 40, 0, 0, 0}, '{0, 1, 0, 0, 0});
    endtask

    task automatic test_reset_mid_scan();
        load_frame(100, 40, 8, 1'b0);
        bus.CounterX = 10'd100; bus.CounterY = 10'd40; bus.pix_valid = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if (bus.pixel_on !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_on: pixel_on=%b expected 1", bus.pixel_on);
        end
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #1;
            n_checks++;
            if (bus.pixel_valid !== 1'b0 || bus.pixel_on !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_reset cyc%0d: valid/on=%b%b expected 00", i, bus.pixel_valid, bus.pixel_on);
            end
        end
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            n_checks++;
            if (bus.pixel_valid !== (i >= 1) || bus.pixel_on !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset cyc%0d: valid/on=%b%b expected %b0",
                         i, bus.pixel_valid, bus.pixel_on, (i >= 1));
            end
        end
        load_frame(100, 40, 8, 1'b0);
        @(posedge clock); #1;
        n_checks++;
        if (bus.pixel_on !== 1'b0) begin
            n_fail++;
            $display("FAIL reload_old: pixel_on=%b expected 0", bus.pixel_on);
        end
        @(posedge clock); #1;
        n_checks++;
        if (bus.pixel_on !== 1'b1) begin
            n_fail++;
            $display("FAIL reload_new: pixel_on=%b expected 1", bus.pixel_on);
        end
        bus.pix_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic test_back_to_back();
        exp_t q[$];
        exp_t e;
        int   cx, cy;
        load_frame($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 15), 1'b0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                cx = (m_sx + $urandom_range(0, W + 1)) % HA;
                cy = (m_sy + $urandom_range(0, H + 1)) % VA;
            end else begin
                cx = $urandom_range(0, 700);
                cy = $urandom_range(0, 520);
            end
            bus.CounterX  = 10'(cx);
            bus.CounterY  = 10'(cy);
            bus.pix_valid = ($urandom_range(0, 7) != 0);
            bus.frame_start = ($urandom_range(0, 59) == 0);
            bus.DigitX = 10'($urandom_range(0, 1023));
            bus.DigitY = 10'($urandom_range(0, 1023));
            bus.digit_value = 4'($urandom_range(0, 15));
            bus.digit_blank = ($urandom_range(0, 4) == 0);
            q.push_back('{v: bus.pix_valid, on: model_on(cx, cy, bus.pix_valid), x: cx, y: cy});
            @(posedge clock); #1;
            if (bus.frame_start) begin
                m_sx = int'(bus.DigitX) % HA; m_sy = int'(bus.DigitY) % VA;
                m_val = int'(bus.digit_value); m_blank = bus.digit_blank;
            end
            bus.frame_start = 1'b0;
            if (q.size() == 2) begin
                e = q.pop_front();
                n_checks++;
                if (bus.pixel_valid !== e.v || bus.pixel_on !== e.on) begin
                    n_fail++;
                    $display("FAIL stream (%0d,%0d) glyph=%0d at (%0d,%0d): valid/on=%b%b expected %b%b",
                             e.x, e.y, m_val, m_sx, m_sy, bus.pixel_valid, bus.pixel_on, e.v, e.on);
                end
            end
        end
        bus.pix_valid = 1'b0;
        @(posedge clock); #1;
        e = q.pop_front();
        n_checks++;
        if (bus.pixel_valid !== e.v || bus.pixel_on !== e.on) begin
            n_fail++;
            $display("FAIL stream_tail (%0d,%0d): valid/on=%b%b expected %b%b",
                     e.x, e.y, bus.pixel_valid, bus.pixel_on, e.v, e.on);
        end
    endtask

    initial begin
        bus.frame_start = 1'b0; bus.pix_valid = 1'b0;
        bus.CounterX = '0; bus.CounterY = '0; bus.DigitX = '0; bus.DigitY = '0;
        bus.digit_value = '0; bus.digit_blank = 1'b1;
        reset = 1'b1;
        model_reset();
        #1;
        test_reset();
        test_glyph_eight();
        test_glyph_one();
        test_wrap();
        test_frame_latch();
        test_reset_mid_scan();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
